uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant lasts until the last byte, a burst limit, or an idle timeout on the owning requester.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          tx_vld,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_rdy,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned IdW1 = IdW + 1;
    localparam int unsigned BcW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int unsigned IcW  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
        $fatal(1, "uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (DATA_WIDTH < 2) begin : gen_bad_data_width
        $fatal(1, "uart_tx_arbiter: DATA_WIDTH must be at least 2");
    end

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e         state_q;
    logic [IdW-1:0] gnt_q;
    logic [IdW-1:0] rr_ptr_q;
    logic [BcW-1:0] beat_cnt_q;
    logic [IcW-1:0] idle_cnt_q;
    logic           busy_q;

    // Round-robin pick: first valid requester scanning upward from rr_ptr_q.
    logic           pick_vld;
    logic [IdW-1:0] pick_id;
    logic [IdW1-1:0] idx_w;

    always_comb begin
        pick_vld = 1'b0;
        pick_id  = rr_ptr_q;
        idx_w    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + IdW1'(k);
            if (32'(idx_w) >= NUM_REQ) begin
                idx_w = idx_w - IdW1'(NUM_REQ);
            end
            if (!pick_vld && req_vld[idx_w[IdW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = idx_w[IdW-1:0];
            end
        end
    end

    logic           locked;
    logic           cur_vld;
    logic           cur_last;
    logic           accept;
    logic           rel_last;
    logic           rel_burst;
    logic           rel_idle;
    logic           release_now;
    logic [IdW-1:0] next_ptr;

    assign locked      = (state_q == StLocked);
    assign cur_vld     = req_vld[gnt_q];
    assign cur_last    = req_last[gnt_q];
    assign accept      = locked && cur_vld && tx_rdy;
    assign rel_last    = accept && cur_last;
    assign rel_burst   = (MAX_BURST > 0) && accept && (32'(beat_cnt_q) + 32'd1 == MAX_BURST);
    assign rel_idle    = (IDLE_TIMEOUT > 0) && locked && !cur_vld &&
                         (32'(idle_cnt_q) == IDLE_TIMEOUT - 1);
    assign release_now = rel_last || rel_burst || rel_idle;
    assign next_ptr    = (32'(gnt_q) + 32'd1 == NUM_REQ) ? '0 : gnt_q + IdW'(1);

    // Datapath is a pure mux off the registered grant; no byte is accepted while idle.
    always_comb begin
        req_rdy = '0;
        tx_vld  = 1'b0;
        tx_data = '0;
        if (locked) begin
            tx_vld         = cur_vld;
            req_rdy[gnt_q] = tx_rdy;
            if (cur_vld) begin
                tx_data = req_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        state_q    <= StLocked;
                        busy_q     <= 1'b1;
                        gnt_q      <= pick_id;
                        beat_cnt_q <= '0;
                        idle_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    if (accept && beat_cnt_q != '1) begin
                        beat_cnt_q <= beat_cnt_q + BcW'(1);
                    end
                    if (cur_vld) begin
                        idle_cnt_q <= '0;
                    end else if (IDLE_TIMEOUT > 0 && !rel_idle) begin
                        idle_cnt_q <= idle_cnt_q + IcW'(1);
                    end
                    if (release_now) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_id = gnt_q;
    assign busy   = busy_q;

    // A release without an accepted beat can only be a timeout, so the owner must be idle.
    assert property (@(posedge clk) disable iff (rst)
        (release_now && !accept) |-> !cur_vld);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: instance a uses default limits, instance b uses MAX_BURST=4, IDLE_TIMEOUT=8.
// A transaction-level owner/pointer model checks every cycle; directed sequences cover corner cases.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NU = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   vld  [NU];
    logic [N*W-1:0] dat  [NU];
    logic [N-1:0]   lst  [NU];
    logic           trdy [NU];
    logic [N-1:0]   rdy  [NU];
    logic           txv  [NU];
    logic [W-1:0]   txd  [NU];
    logic [1:0]     gid  [NU];
    logic           bsy  [NU];
    logic [N-1:0]   hs   [NU];

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(16), .IDLE_TIMEOUT(1024)) u_dut_a (
        .clk(clk), .rst(rst), .req_vld(vld[0]), .req_data(dat[0]), .req_last(lst[0]),
        .req_rdy(rdy[0]), .tx_vld(txv[0]), .tx_data(txd[0]), .tx_rdy(trdy[0]),
        .gnt_id(gid[0]), .busy(bsy[0])
    );

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4), .IDLE_TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst), .req_vld(vld[1]), .req_data(dat[1]), .req_last(lst[1]),
        .req_rdy(rdy[1]), .tx_vld(txv[1]), .tx_data(txd[1]), .tx_rdy(trdy[1]),
        .gnt_id(gid[1]), .busy(bsy[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (-1 = nobody), last granted id, start of next scan, counters.
    int mb_cfg [NU] = '{16, 4};
    int to_cfg [NU] = '{1024, 8};
    int m_owner [NU];
    int m_gnt   [NU];
    int m_ptr   [NU];
    int m_sent  [NU];
    int m_quiet [NU];
    bit m_on = 1'b0;

    typedef struct {
        logic [N-1:0]   vld;
        logic [N*W-1:0] dat;
        logic [N-1:0]   lst;
        logic           trdy;
        logic           busy;
        logic [1:0]     gnt;
        logic           txv;
        logic [W-1:0]   txd;
        logic [N-1:0]   rdy;
    } vec_t;

    vec_t tbl [8];
    int   sent0;
    int   sent1;
    int   rem [NU][N];
    int   gap [NU][N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp(input int u);
        logic [N-1:0] e_rdy;
        logic         e_txv;
        logic [W-1:0] e_txd;
        e_rdy = '0;
        e_txv = 1'b0;
        e_txd = '0;
        if (m_owner[u] >= 0) begin
            e_txv = vld[u][m_owner[u]];
            if (trdy[u]) e_rdy[m_owner[u]] = 1'b1;
            if (e_txv) e_txd = dat[u][m_owner[u]*W +: W];
        end
        chk($sformatf("model u%0d busy", u), 32'(bsy[u]), 32'(m_owner[u] >= 0));
        chk($sformatf("model u%0d gnt_id", u), 32'(gid[u]), m_gnt[u]);
        chk($sformatf("model u%0d tx_vld", u), 32'(txv[u]), 32'(e_txv));
        chk($sformatf("model u%0d tx_data", u), 32'(txd[u]), 32'(e_txd));
        chk($sformatf("model u%0d req_rdy", u), 32'(rdy[u]), 32'(e_rdy));
    endtask

    task automatic model_step(input int u);
        int o;
        bit took;
        bit done;
        if (rst) begin
            m_owner[u] = -1;
            m_gnt[u]   = 0;
            m_ptr[u]   = 0;
            m_sent[u]  = 0;
            m_quiet[u] = 0;
            return;
        end
        o = m_owner[u];
        if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr[u] + k) % N;
                if (vld[u][c]) begin
                    m_owner[u] = c;
                    m_gnt[u]   = c;
                    m_sent[u]  = 0;
                    m_quiet[u] = 0;
                    break;
                end
            end
        end else begin
            took = vld[u][o] && trdy[u];
            if (took) m_sent[u]++;
            done = (took && lst[u][o]) ||
                   (mb_cfg[u] > 0 && took && m_sent[u] == mb_cfg[u]) ||
                   (to_cfg[u] > 0 && !vld[u][o] && m_quiet[u] == to_cfg[u] - 1);
            m_quiet[u] = vld[u][o] ? 0 : m_quiet[u] + 1;
            if (done) begin
                m_owner[u] = -1;
                m_ptr[u]   = (o + 1) % N;
            end
        end
    endtask

    // Inputs are changed at the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        #1;
        for (int u = 0; u < NU; u++) begin
            hs[u] = vld[u] & rdy[u];
            if (m_on) model_cmp(u);
        end
        @(posedge clk);
        for (int u = 0; u < NU; u++) model_step(u);
        m_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        for (int u = 0; u < NU; u++) begin
            vld[u]  = '0;
            dat[u]  = '0;
            lst[u]  = '0;
            trdy[u] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Single packet on req0, then a contender on req3 proves rr_ptr moved to 1.
        tbl[0] = '{4'b0001, 32'h0000_0041, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
        tbl[1] = '{4'b0001, 32'h0000_0041, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 8'h41, 4'b0001};
        tbl[2] = '{4'b0001, 32'h0000_0042, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 8'h42, 4'b0000};
        tbl[3] = '{4'b0001, 32'h0000_0042, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 8'h42, 4'b0001};
        tbl[4] = '{4'b0001, 32'h0000_0043, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 8'h43, 4'b0001};
        tbl[5] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
        tbl[6] = '{4'b1001, 32'h5A00_0044, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
        tbl[7] = '{4'b1001, 32'h5A00_0044, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 8'h5A, 4'b0000};

        do_reset();
        #1;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("reset u%0d busy", u), 32'(bsy[u]), 0);
            chk($sformatf("reset u%0d gnt_id", u), 32'(gid[u]), 0);
            chk($sformatf("reset u%0d tx_vld", u), 32'(txv[u]), 0);
            chk($sformatf("reset u%0d tx_data", u), 32'(txd[u]), 0);
            chk($sformatf("reset u%0d req_rdy", u), 32'(rdy[u]), 0);
        end

        foreach (tbl[r]) begin
            for (int u = 0; u < NU; u++) begin
                vld[u]  = tbl[r].vld;
                dat[u]  = tbl[r].dat;
                lst[u]  = tbl[r].lst;
                trdy[u] = tbl[r].trdy;
            end
            #1;
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("vec%0d u%0d busy", r, u), 32'(bsy[u]), 32'(tbl[r].busy));
                chk($sformatf("vec%0d u%0d gnt_id", r, u), 32'(gid[u]), 32'(tbl[r].gnt));
                chk($sformatf("vec%0d u%0d tx_vld", r, u), 32'(txv[u]), 32'(tbl[r].txv));
                chk($sformatf("vec%0d u%0d tx_data", r, u), 32'(txd[u]), 32'(tbl[r].txd));
                chk($sformatf("vec%0d u%0d req_rdy", r, u), 32'(rdy[u]), 32'(tbl[r].rdy));
            end
            tick();
        end

        // Round-robin: every requester keeps a 1-byte packet pending.
        do_reset();
        for (int u = 0; u < NU; u++) begin
            vld[u]  = '1;
            lst[u]  = '1;
            dat[u]  = 32'hA3A2_A1A0;
            trdy[u] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            for (int u = 0; u < NU; u++) chk($sformatf("rr%0d u%0d gap", k, u), 32'(bsy[u]), 0);
            tick();
            #1;
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("rr%0d u%0d busy", k, u), 32'(bsy[u]), 1);
                chk($sformatf("rr%0d u%0d gnt_id", k, u), 32'(gid[u]), k % 4);
                chk($sformatf("rr%0d u%0d tx_data", k, u), 32'(txd[u]), 32'hA0 + k % 4);
            end
            tick();
        end

        // Packet lock on instance a: req1 sends 5 bytes while req2 waits.
        do_reset();
        vld[0]  = 4'b0110;
        dat[0]  = 32'h00C0_1000;
        lst[0]  = 4'b0100;
        trdy[0] = 1'b1;
        sent1   = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("lock c%0d req_rdy2", c), 32'(rdy[0][2]), 0);
            if (c >= 1) chk($sformatf("lock c%0d gnt_id", c), 32'(gid[0]), 1);
            tick();
            if (hs[0][1]) begin
                sent1++;
                dat[0][15:8] = 8'(8'h10 + sent1);
                lst[0][1]    = (sent1 == 4);
                if (sent1 == 5) vld[0][1] = 1'b0;
            end
        end
        chk("lock bytes sent", sent1, 5);
        #1;
        chk("lock gap busy", 32'(bsy[0]), 0);
        tick();
        #1;
        chk("lock next gnt_id", 32'(gid[0]), 2);
        chk("lock next req_rdy2", 32'(rdy[0][2]), 1);
        tick();

        // Burst limit on instance b: req0 streams without last, req3 waits.
        do_reset();
        vld[1]  = 4'b1001;
        dat[1]  = 32'hE300_0000;
        lst[1]  = 4'b1000;
        trdy[1] = 1'b1;
        sent0   = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (c == 5) begin
                chk("burst release busy", 32'(bsy[1]), 0);
                chk("burst first chunk", sent0, 4);
            end
            if (c == 6) chk("burst req3 gnt_id", 32'(gid[1]), 3);
            if (c == 8) begin
                chk("burst regrant gnt_id", 32'(gid[1]), 0);
                chk("burst regrant tx_data", 32'(txd[1]), 4);
            end
            if (c == 12) chk("burst second release busy", 32'(bsy[1]), 0);
            tick();
            if (hs[1][0]) begin
                sent0++;
                dat[1][7:0] = 8'(sent0);
            end
            if (hs[1][3]) vld[1][3] = 1'b0;
        end
        chk("burst total bytes", sent0, 8);

        // Idle timeout on instance b: req2 goes quiet for 8 cycles, req3 waits.
        do_reset();
        vld[1]  = 4'b0100;
        dat[1]  = 32'h3322_0000;
        trdy[1] = 1'b1;
        tick();
        #1;
        chk("timeout gnt_id", 32'(gid[1]), 2);
        tick();
        vld[1] = 4'b1000;
        lst[1] = 4'b1000;
        for (int c = 2; c < 10; c++) begin
            #1;
            chk($sformatf("timeout c%0d busy", c), 32'(bsy[1]), 1);
            tick();
        end
        #1;
        chk("timeout release busy", 32'(bsy[1]), 0);
        tick();
        #1;
        chk("timeout next gnt_id", 32'(gid[1]), 3);
        chk("timeout next busy", 32'(bsy[1]), 1);
        tick();

        // Reset in the middle of a packet from req1.
        do_reset();
        for (int u = 0; u < NU; u++) begin
            vld[u]  = 4'b0010;
            dat[u]  = 32'h0000_5100;
            trdy[u] = 1'b1;
        end
        tick();
        tick();
        tick();
        #1;
        for (int u = 0; u < NU; u++) chk($sformatf("midrst u%0d pre gnt_id", u), 32'(gid[u]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("midrst u%0d req_rdy", u), 32'(rdy[u]), 0);
            chk($sformatf("midrst u%0d tx_vld", u), 32'(txv[u]), 0);
            chk($sformatf("midrst u%0d gnt_id", u), 32'(gid[u]), 0);
            chk($sformatf("midrst u%0d busy", u), 32'(bsy[u]), 0);
        end

        // Backpressure: transmitter stalls 20 cycles; no beats counted, no timeout.
        do_reset();
        for (int u = 0; u < NU; u++) begin
            vld[u] = 4'b0001;
            dat[u] = 32'h0000_0077;
        end
        tick();
        for (int c = 0; c < 20; c++) begin
            #1;
            for (int u = 0; u < NU; u++) begin
                chk($sformatf("bp c%0d u%0d tx_vld", c, u), 32'(txv[u]), 1);
                chk($sformatf("bp c%0d u%0d tx_data", c, u), 32'(txd[u]), 32'h77);
                chk($sformatf("bp c%0d u%0d busy", c, u), 32'(bsy[u]), 1);
            end
            tick();
        end
        for (int u = 0; u < NU; u++) trdy[u] = 1'b1;
        tick();
        for (int u = 0; u < NU; u++) begin
            trdy[u] = 1'b0;
            dat[u]  = 32'h0000_0078;
        end
        #1;
        for (int u = 0; u < NU; u++) chk($sformatf("bp u%0d after accept busy", u), 32'(bsy[u]), 1);
        tick();

        // Randomized traffic against the model, protocol-abiding requesters.
        do_reset();
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < N; i++) begin
                rem[u][i] = 0;
                gap[u][i] = 0;
            end
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int u = 0; u < NU; u++) begin
                for (int i = 0; i < N; i++) begin
                    if (!vld[u][i]) begin
                        if (gap[u][i] > 0) begin
                            gap[u][i]--;
                        end else begin
                            if (rem[u][i] == 0) rem[u][i] = $urandom_range(1, 20);
                            vld[u][i]          = 1'b1;
                            dat[u][i*W +: W]   = 8'($urandom);
                            lst[u][i]          = (rem[u][i] == 1);
                        end
                    end
                end
                trdy[u] = ($urandom_range(0, 3) != 0);
            end
            tick();
            for (int u = 0; u < NU; u++) begin
                for (int i = 0; i < N; i++) begin
                    if (hs[u][i]) begin
                        vld[u][i] = 1'b0;
                        rem[u][i]--;
                        gap[u][i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
